core_sequencer: RTL

- Multi-cycle control FSM for the RV32I softcore.
- Consumes the instruction decoder's control and exception outputs, plus instruction and data memory handshakes.
- Issues per-stage strobes to the IR, register file, PC, CSR file and data memory.
- Owns trap entry: mcause generation and PC redirect to mtvec.

---
 rtl/core_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
`default_nettype none
// core_sequencer: multi-cycle control FSM for the RV32I softcore (fetch/decode/exec/mem/wb/trap/halt).
// Optional build macro DM_TIMEOUT_EN adds a data-memory wait-cycle limit that traps with a bus-fault cause.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       im_valid,
    input  logic       dm_ready,
    input  logic       dec_regwrite,
    input  logic       dec_jump,
    input  logic       dec_jr,
    input  logic       dec_br,
    input  logic       dec_pc_update,
    input  logic       dec_pc_mepc,
    input  logic       dec_dm_we,
    input  logic [3:0] dec_dm_be,
    input  logic       dec_csr_write,
    input  logic       dec_csr_set,
    input  logic       dec_csr_clear,
    input  logic       dec_exc_unsupported,
    input  logic       dec_exc_illegal,
    input  logic       dec_exc_load_mis,
    input  logic       dec_exc_store_mis,
    input  logic       dec_bug_onehot,
    input  logic       br_taken,
    output logic       im_req,
    output logic       ir_we,
    output logic       dm_req,
    output logic       dm_we,
    output logic       rf_we,
    output logic       csr_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       trap_enter,
    output logic [3:0] mcause,
    output logic       instret,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] mcause_next;

    if (MEM_TIMEOUT >= (1 << TO_W)) begin : g_param_check
        $error("core_sequencer: MEM_TIMEOUT must be below 2**TO_W");
    end

`ifdef DM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside S_MEM so every access starts counting from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != S_MEM) begin
            to_cnt <= '0;
        end else if (!dm_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            mcause <= 4'd0;
        end else begin
            state  <= state_next;
            mcause <= mcause_next;
        end
    end

    always_comb begin
        state_next  = state;
        mcause_next = mcause;
        im_req      = 1'b0;
        ir_we       = 1'b0;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        rf_we       = 1'b0;
        csr_we      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        trap_enter  = 1'b0;
        instret     = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                // The state register already sits in S_FETCH while reset is held.
                im_req = !reset;
                ir_we  = im_valid && !reset;
                if (im_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_bug_onehot) begin
                    state_next = S_HALT;
                end else if (dec_exc_unsupported || dec_exc_illegal) begin
                    mcause_next = 4'd2;
                    state_next  = S_TRAP;
                end else if (dec_exc_load_mis) begin
                    mcause_next = 4'd4;
                    state_next  = S_TRAP;
                end else if (dec_exc_store_mis) begin
                    mcause_next = 4'd6;
                    state_next  = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = (dec_dm_be != 4'd0) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = dec_dm_we;
                if (dm_ready) begin
                    state_next = S_WB;
                end
`ifdef DM_TIMEOUT_EN
                else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                    mcause_next = dec_dm_we ? 4'd7 : 4'd5;
                    state_next  = S_TRAP;
                end
`endif
            end
            S_WB: begin
                rf_we   = dec_regwrite;
                csr_we  = dec_csr_write | dec_csr_set | dec_csr_clear;
                pc_we   = 1'b1;
                instret = 1'b1;
                if (dec_pc_mepc) begin
                    pc_sel = 2'b10;
                end else if (dec_jump || dec_jr || (dec_br && br_taken)) begin
                    pc_sel = 2'b01;
                end
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap_enter = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = 2'b11;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // dec_pc_update is implied by the WB/TRAP pc_we strobes and carries no extra meaning here.
    logic unused_ok;
    assign unused_ok = dec_pc_update;

endmodule
`default_nettype wire
